// File: rtl/fwd_pkg.sv
// fwd_pkg: shared constants and helpers for the forwarding/hazard controller.
package fwd_pkg;
   localparam int FWD_SEL_RF = 0;
   localparam int REG_AW_DEF = 5;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/fwd_src_sel.sv
// fwd_src_sel: priority forward-stage match for one source operand.
module fwd_src_sel
   import fwd_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF,
   parameter int N_STG  = 2,
   parameter int SEL_W  = clog2(N_STG + 1)
) (
   input  logic [REG_AW-1:0]       src,
   input  logic [N_STG-1:0]        stgWrEn,
   input  logic [N_STG*REG_AW-1:0] stgRd,
   input  logic [N_STG-1:0]        stgDataRdy,
   output logic [SEL_W-1:0]        sel,
   output logic                    notRdy
);
   // Scan oldest to youngest so the youngest producer overwrites last.
   always_comb begin
      sel = SEL_W'(FWD_SEL_RF);
      notRdy = 1'b0;
      for (int k = N_STG - 1; k >= 0; k--)
         if (stgWrEn[k] && stgRd[k*REG_AW +: REG_AW] != '0 && stgRd[k*REG_AW +: REG_AW] == src) begin
            sel = SEL_W'(k + 1);
            notRdy = !stgDataRdy[k];
         end
   end
endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: operand forwarding, load-use stall and long-op scoreboard.
// Define FWD_PERF_CNT_EN to add saturating stall/forward performance counters.
module fwd_hazard_ctrl
   import fwd_pkg::*;
#(
   parameter  int REG_AW = REG_AW_DEF,
   parameter  int N_SRC  = 2,
   parameter  int N_STG  = 2,
   parameter  int LAT_W  = 4,
   localparam int SEL_W  = clog2(N_STG + 1),
   localparam int NREG   = 2 ** REG_AW
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_SRC*REG_AW-1:0] ex_src_reg,
   input  logic [N_SRC*REG_AW-1:0] id_src_reg,
   input  logic [N_STG-1:0]        stg_wr_en,
   input  logic [N_STG*REG_AW-1:0] stg_rd,
   input  logic [N_STG-1:0]        stg_data_rdy,
   input  logic                    lop_issue,
   input  logic [REG_AW-1:0]       lop_rd,
   input  logic [LAT_W-1:0]        lop_lat,
   output logic [N_SRC*SEL_W-1:0]  fwd_sel,
   output logic                    ex_stall,
   output logic                    id_stall,
   output logic [NREG-1:0]         lop_done,
   output logic [NREG-1:0]         sb_busy
`ifdef FWD_PERF_CNT_EN
   ,
   output logic [31:0]             perf_stall_cyc,
   output logic [31:0]             perf_fwd_cnt
`endif
);
   logic [N_SRC-1:0] opNotRdy, idRaw;
   logic             accept;
   logic [LAT_W-1:0] latEff;

   genvar j, r;
   generate
      for (j = 0; j < N_SRC; j++) begin : g_src
         fwd_src_sel #(.REG_AW(REG_AW), .N_STG(N_STG), .SEL_W(SEL_W)) u_sel (
            .src        (ex_src_reg[j*REG_AW +: REG_AW]),
            .stgWrEn    (stg_wr_en),
            .stgRd      (stg_rd),
            .stgDataRdy (stg_data_rdy),
            .sel        (fwd_sel[j*SEL_W +: SEL_W]),
            .notRdy     (opNotRdy[j])
         );
         assign idRaw[j] = id_src_reg[j*REG_AW +: REG_AW] != '0 && sb_busy[id_src_reg[j*REG_AW +: REG_AW]];
      end
   endgenerate

   assign ex_stall = |opNotRdy;
   assign id_stall = ex_stall || |idRaw || (lop_issue && sb_busy[lop_rd]);
   assign accept   = lop_issue && !id_stall && lop_rd != '0;
   assign latEff   = lop_lat == '0 ? LAT_W'(1) : lop_lat;

   // lop_done is registered from next state so it is high during the cnt==1 cycle.
   generate
      for (r = 0; r < NREG; r++) begin : g_sb
         if (r == 0) begin : g_zero
            assign sb_busy[r]  = 1'b0;
            assign lop_done[r] = 1'b0;
         end else begin : g_ent
            logic             busyQ, doneQ, load, busyNext;
            logic [LAT_W-1:0] cnt, cntNext;
            always_comb begin
               load = accept && lop_rd == REG_AW'(r);
               busyNext = load || (busyQ && cnt != LAT_W'(1));
               cntNext = load ? latEff : busyQ ? cnt - LAT_W'(1) : cnt;
            end
            always_ff @(posedge clk or negedge rst_n)
               if (!rst_n) begin
                  busyQ <= 1'b0;
                  doneQ <= 1'b0;
                  cnt <= '0;
               end else begin
                  busyQ <= busyNext;
                  doneQ <= busyNext && cntNext == LAT_W'(1);
                  cnt <= cntNext;
               end
            assign sb_busy[r]  = busyQ;
            assign lop_done[r] = doneQ;
         end
      end
   endgenerate

`ifdef FWD_PERF_CNT_EN
   logic [31:0] nFwd;
   logic [32:0] fwdSum;
   always_comb begin
      nFwd = '0;
      for (int i = 0; i < N_SRC; i++)
         if (fwd_sel[i*SEL_W +: SEL_W] != '0) nFwd = nFwd + 32'd1;
      fwdSum = {1'b0, perf_fwd_cnt} + {1'b0, ex_stall ? 32'd0 : nFwd};
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         perf_stall_cyc <= '0;
         perf_fwd_cnt <= '0;
      end else begin
         if (id_stall && perf_stall_cyc != '1) perf_stall_cyc <= perf_stall_cyc + 32'd1;
         perf_fwd_cnt <= fwdSum[32] ? '1 : fwdSum[31:0];
      end
`endif
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed and randomized checks against a completion-time reference model.
module tb_fwd_hazard_ctrl;
   localparam int REG_AW = 5, N_SRC = 2, N_STG = 2, LAT_W = 4, SEL_W = 2, NREG = 32;

   logic                    clk, rst_n;
   logic [N_SRC*REG_AW-1:0] ex_src_reg, id_src_reg;
   logic [N_STG-1:0]        stg_wr_en, stg_data_rdy;
   logic [N_STG*REG_AW-1:0] stg_rd;
   logic                    lop_issue;
   logic [REG_AW-1:0]       lop_rd;
   logic [LAT_W-1:0]        lop_lat;
   logic [N_SRC*SEL_W-1:0]  fwd_sel;
   logic                    ex_stall, id_stall;
   logic [NREG-1:0]         lop_done, sb_busy;

   fwd_hazard_ctrl #(.REG_AW(REG_AW), .N_SRC(N_SRC), .N_STG(N_STG), .LAT_W(LAT_W)) dut (
      .clk(clk), .rst_n(rst_n), .ex_src_reg(ex_src_reg), .id_src_reg(id_src_reg),
      .stg_wr_en(stg_wr_en), .stg_rd(stg_rd), .stg_data_rdy(stg_data_rdy),
      .lop_issue(lop_issue), .lop_rd(lop_rd), .lop_lat(lop_lat),
      .fwd_sel(fwd_sel), .ex_stall(ex_stall), .id_stall(id_stall),
      .lop_done(lop_done), .sb_busy(sb_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nChk = 0, nErr = 0;
   int cyc = 0;
   int doneAt[NREG];
   bit act[NREG];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nChk++;
      if (got !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // A register is busy from the cycle after issue up to and including its done cycle.
   function automatic bit mBusy(input int r);
      return act[r] && doneAt[r] >= cyc;
   endfunction

   function automatic logic [SEL_W-1:0] refSel(input logic [REG_AW-1:0] src);
      for (int k = 1; k <= N_STG; k++)
         if (stg_wr_en[k-1] && stg_rd[(k-1)*REG_AW +: REG_AW] != 0 && stg_rd[(k-1)*REG_AW +: REG_AW] == src)
            return SEL_W'(k);
      return '0;
   endfunction

   task automatic evalCycle(input string tag);
      logic [N_SRC*SEL_W-1:0] eSel;
      logic [NREG-1:0] eBusy, eDone;
      logic [SEL_W-1:0] s;
      logic [REG_AW-1:0] src;
      bit eEx, eId, acc;
      #1;
      for (int r = 0; r < NREG; r++) begin
         eBusy[r] = mBusy(r);
         eDone[r] = act[r] && doneAt[r] == cyc;
      end
      eEx = 0;
      for (int i = 0; i < N_SRC; i++) begin
         s = refSel(ex_src_reg[i*REG_AW +: REG_AW]);
         eSel[i*SEL_W +: SEL_W] = s;
         if (s != 0 && !stg_data_rdy[int'(s) - 1]) eEx = 1;
      end
      eId = eEx;
      for (int i = 0; i < N_SRC; i++) begin
         src = id_src_reg[i*REG_AW +: REG_AW];
         if (src != 0 && eBusy[src]) eId = 1;
      end
      if (lop_issue && eBusy[lop_rd]) eId = 1;
      check({tag, "_sel"}, 64'(fwd_sel), 64'(eSel));
      check({tag, "_exst"}, 64'(ex_stall), 64'(eEx));
      check({tag, "_idst"}, 64'(id_stall), 64'(eId));
      check({tag, "_busy"}, 64'(sb_busy), 64'(eBusy));
      check({tag, "_done"}, 64'(lop_done), 64'(eDone));
      acc = lop_issue && !eId && lop_rd != 0;
      @(posedge clk);
      if (acc) begin
         act[lop_rd] = 1;
         doneAt[lop_rd] = cyc + (lop_lat == 0 ? 1 : int'(lop_lat));
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic quiet();
      ex_src_reg = '0; id_src_reg = '0; stg_wr_en = '0; stg_rd = '0;
      stg_data_rdy = '1; lop_issue = 0; lop_rd = '0; lop_lat = '0;
   endtask

   task automatic issue(input int rd, input int lat);
      lop_issue = 1; lop_rd = REG_AW'(rd); lop_lat = LAT_W'(lat);
   endtask

   function automatic logic [REG_AW-1:0] rr();
      return REG_AW'($urandom_range(0, 7));
   endfunction

   initial begin
      rst_n = 0;
      quiet();
      for (int r = 0; r < NREG; r++) begin act[r] = 0; doneAt[r] = 0; end
      repeat (2) @(negedge clk);
      #1;
      check("rst_busy", 64'(sb_busy), 64'd0);
      check("rst_done", 64'(lop_done), 64'd0);
      check("rst_sel", 64'(fwd_sel), 64'd0);
      @(negedge clk);
      rst_n = 1;

      // youngest producer wins
      ex_src_reg = {5'd3, 5'd3}; stg_wr_en = 2'b11; stg_rd = {5'd3, 5'd3};
      #1 check("t1_sel", 64'(fwd_sel), 64'b0101);
      check("t1_stall", 64'(ex_stall), 64'd0);
      evalCycle("t1");
      stg_wr_en = 2'b10; stg_rd = {5'd7, 5'd0}; ex_src_reg = {5'd0, 5'd7};
      #1 check("t2_sel", 64'(fwd_sel), 64'b0010);
      evalCycle("t2");
      stg_rd = {5'd0, 5'd0}; ex_src_reg = {5'd0, 5'd0};
      #1 check("t2_r0", 64'(fwd_sel), 64'd0);
      evalCycle("t2z");

      // load-use
      stg_wr_en = 2'b01; stg_rd = {5'd0, 5'd4}; stg_data_rdy = 2'b10; ex_src_reg = {5'd0, 5'd4};
      #1 check("t3_ex", 64'(ex_stall), 64'd1);
      check("t3_id", 64'(id_stall), 64'd1);
      evalCycle("t3");
      stg_data_rdy = 2'b11;
      #1 check("t3_exr", 64'(ex_stall), 64'd0);
      check("t3_idr", 64'(id_stall), 64'd0);
      evalCycle("t3r");

      // long op lat=3, RAW stall on rs=9
      quiet(); issue(9, 3);
      evalCycle("t4i");
      lop_issue = 0; id_src_reg = {5'd0, 5'd9};
      for (int c = 1; c <= 4; c++) begin
         #1 check("t4_busy", 64'(sb_busy[9]), 64'(c <= 3));
         check("t4_done", 64'(lop_done[9]), 64'(c == 3));
         check("t4_raw", 64'(id_stall), 64'(c <= 3));
         evalCycle("t4");
      end
      quiet(); issue(10, 0);
      evalCycle("t4z");
      lop_issue = 0;
      #1 check("t4z_busy", 64'(sb_busy[10]), 64'd1);
      check("t4z_done", 64'(lop_done[10]), 64'd1);
      evalCycle("t4z1");
      #1 check("t4z_clr", 64'(sb_busy[10]), 64'd0);

      // WAW: reissue to busy reg stalls until clear
      issue(9, 4);
      evalCycle("t5i");
      issue(9, 2);
      for (int c = 1; c <= 5; c++) begin
         #1 check("t5_waw", 64'(id_stall), 64'(c <= 4));
         evalCycle("t5");
      end
      lop_issue = 0;
      #1 check("t5_rearm", 64'(sb_busy[9]), 64'd1);
      repeat (3) evalCycle("t5d");
      issue(5, 3);
      evalCycle("t5a");
      issue(6, 2);
      evalCycle("t5b");
      lop_issue = 0;
      evalCycle("t5c");
      #1 check("t5_both", 64'(lop_done[6:5]), 64'b11);
      evalCycle("t5e");

      // async reset mid-countdown
      issue(12, 8);
      evalCycle("t6i");
      lop_issue = 0;
      evalCycle("t6w");
      rst_n = 0;
      #1 check("t6_busy", 64'(sb_busy), 64'd0);
      check("t6_done", 64'(lop_done), 64'd0);
      for (int r = 0; r < NREG; r++) act[r] = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      issue(12, 2);
      evalCycle("t6n");
      lop_issue = 0;
      #1 check("t6_new", 64'(sb_busy[12]), 64'd1);
      repeat (3) evalCycle("t6d");

      // randomized traffic
      repeat (600) begin
         ex_src_reg = {rr(), rr()};
         id_src_reg = {rr(), rr()};
         stg_wr_en = N_STG'($urandom);
         stg_rd = {rr(), rr()};
         stg_data_rdy = {$urandom_range(0, 4) != 0, $urandom_range(0, 4) != 0};
         lop_issue = $urandom_range(0, 2) == 0;
         lop_rd = rr();
         lop_lat = LAT_W'($urandom_range(0, 6));
         evalCycle("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", nChk, nErr);
      $finish;
   end
endmodule
